// File: rtl/tick_bcd_seg_counter_if.sv
// User IO bundle for the tick-driven BCD seven-segment digit.
// io_in carries clock, reset and controls; io_out carries segments and wrap.
interface tick_bcd_seg_counter_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tick_bcd_seg_counter.sv
// Mod-10 up/down digit advanced by a synchronised external slow-clock edge or
// an internal prescaler tick, displayed on a registered seven-segment output.
module tick_bcd_seg_counter #(
  parameter int unsigned PRESCALE_BITS = 13,
  parameter int unsigned SYNC_STAGES   = 2
) (
  tick_bcd_seg_counter_if.slave bus
);

  logic w_clk;
  logic w_rst_n;
  logic w_ext_slow;
  logic w_hold;
  logic w_clear;
  logic w_dir;
  logic w_src_sel;
  logic w_unused;

  assign w_clk      = bus.io_in[0];
  assign w_rst_n    = bus.io_in[1];
  assign w_ext_slow = bus.io_in[2];
  assign w_hold     = bus.io_in[3];
  assign w_clear    = bus.io_in[4];
  assign w_dir      = bus.io_in[5];
  assign w_src_sel  = bus.io_in[6];
  assign w_unused   = bus.io_in[7];

  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_prev;
  logic [PRESCALE_BITS-1:0] r_pre;
  logic [3:0]               r_digit;
  logic [6:0]               r_seg;
  logic                     r_wrap;

  logic       w_ext_tick;
  logic       w_int_tick;
  logic       w_tick;
  logic [3:0] w_next_digit;
  logic       w_next_wrap;

  assign w_ext_tick = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_int_tick = &r_pre;
  assign w_tick     = w_src_sel ? w_int_tick : w_ext_tick;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // clear beats hold beats tick; a tick seen during hold is simply dropped
  always_comb begin
    w_next_digit = r_digit;
    w_next_wrap  = 1'b0;
    if (w_clear) begin
      w_next_digit = '0;
    end else if (w_hold) begin
      w_next_digit = r_digit;
    end else if (w_tick) begin
      if (!w_dir) begin
        if (r_digit == 4'd9) begin
          w_next_digit = '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_digit = r_digit + 4'd1;
        end
      end else begin
        if (r_digit == 4'd0) begin
          w_next_digit = 4'd9;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_digit = r_digit - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pre   <= '0;
      r_digit <= '0;
      r_seg   <= 7'h3F;
      r_wrap  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], w_ext_slow};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_pre   <= r_pre + 1'b1;
      r_digit <= w_next_digit;
      // decode from the next value so segments and digit change together
      r_seg   <= seg_decode(w_next_digit);
      r_wrap  <= w_next_wrap;
    end
  end

  assign bus.io_out = {r_wrap, r_seg};

endmodule

// File: tb/tb_tick_bcd_seg_counter.sv
// Scoreboard bench: an edge-history reference model predicts io_out per clock,
// a monitor compares it; directed phases add explicit boundary checks.
module tb_tick_bcd_seg_counter;
  localparam int P = 4;
  localparam int S = 2;
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0, rst_n = 1'b1, ext = 1'b0, hold = 1'b0, clr = 1'b0;
  logic dir = 1'b0, src = 1'b0, unused_in = 1'b0;

  tick_bcd_seg_counter_if bus ();
  assign bus.io_in = {unused_in, src, dir, clr, hold, ext, rst_n, clk};

  tick_bcd_seg_counter #(.PRESCALE_BITS(P), .SYNC_STAGES(S)) dut (.bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wraps_seen = 0;

  task automatic chk(input string name, input logic [7:0] exp);
    checks++;
    if (bus.io_out !== exp) begin
      errors++;
      $display("FAIL %s: io_out=%h expected=%h at %0t", name, bus.io_out, exp, $time);
    end
  endtask

  // Reference model: digit arithmetic mod 10, ext tick from sampled history
  int m_digit, m_wrap, m_edges;
  bit h[$];
  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_digit = 0;
    m_wrap  = 0;
    m_edges = 0;
    h = {};
    for (int i = 0; i < S + 2; i++) h.push_back(1'b0);
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    bit tick_e, tick_i, tick;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(8'h3F);
    end else begin
      m_edges++;
      h.push_front(ext);
      void'(h.pop_back());
      tick_e = h[S] && !h[S+1];
      tick_i = (m_edges % (1 << P)) == 0;
      tick   = src ? tick_i : tick_e;
      m_wrap = 0;
      if (clr) m_digit = 0;
      else if (hold) m_digit = m_digit;
      else if (tick) begin
        if (!dir) begin
          m_wrap  = (m_digit == 9);
          m_digit = (m_digit + 1) % 10;
        end else begin
          m_wrap  = (m_digit == 0);
          m_digit = (m_digit + 9) % 10;
        end
      end
      exp_q.push_back({m_wrap[0], SEG[m_digit]});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: no expected value queued at %0t", $time);
      end else begin
        chk("scoreboard", exp_q.pop_front());
        if (bus.io_out[7] === 1'b1) wraps_seen++;
      end
    end
  end

  task automatic pulse();
    ext = 1'b1;
    repeat (8) @(negedge clk);
    ext = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wb;
    #1 rst_n = 1'b0;

    // Phase 1: reset held with random inputs, then quiet release
    repeat (20) begin
      @(negedge clk);
      {unused_in, src, dir, clr, hold, ext} = 6'($urandom);
    end
    @(negedge clk);
    {unused_in, src, dir, clr, hold, ext} = '0;
    chk("reset_held", 8'h3F);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_release", 8'h3F);

    // Phase 2: external up count with latency check on the first rise
    wb = wraps_seen;
    ext = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 chk("latency_n1", 8'h3F);
    @(posedge clk); #1 chk("latency_n2", 8'h06);
    repeat (6) @(negedge clk);
    ext = 1'b0;
    repeat (8) @(negedge clk);
    repeat (9) pulse();
    chk("up_wrapped_to_0", 8'h3F);
    checks++;
    if (wraps_seen - wb != 1) begin
      errors++;
      $display("FAIL up_wrap_count: got %0d expected 1", wraps_seen - wb);
    end

    // Phase 3: down count from 0 wraps to 9
    dir = 1'b1;
    ext = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 chk("down_wrap", 8'hEF);
    @(posedge clk); #1 chk("down_after_wrap", 8'h6F);
    repeat (5) @(negedge clk);
    ext = 1'b0;
    repeat (8) @(negedge clk);

    // Phase 4: priority clear > hold > tick
    dir = 1'b0;
    clr = 1'b1; hold = 1'b1;
    pulse();
    clr = 1'b0; hold = 1'b0;
    chk("clear_over_hold", 8'h3F);
    pulse();
    chk("count_to_1", 8'h06);
    hold = 1'b1;
    repeat (3) pulse();
    chk("hold_keeps", 8'h06);
    hold = 1'b0;
    pulse();
    chk("after_hold", 8'h5B);

    // Phase 5: internal prescaler source, ext noise ignored
    src = 1'b1;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk); #1;
      if (i == 15) chk("int_edge15", 8'h3F);
      if (i == 16) chk("int_edge16", 8'h06);
      if (i == 32) chk("int_edge32", 8'h5B);
      if (i == 48) chk("int_edge48", 8'h4F);
      @(negedge clk);
      ext = 1'($urandom);
    end
    src = 1'b0;
    ext = 1'b0;

    // Phase 6: async reset pulse between edges mid-count
    do_reset();
    repeat (7) pulse();
    chk("at_seven", 8'h07);
    ext = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 8'h3F);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("no_count_after_reset", 8'h3F);
    repeat (6) @(negedge clk);
    ext = 1'b0;

    // Phase 7: randomized controls against the model
    repeat (400) begin
      @(negedge clk);
      clr  = ($urandom_range(31) == 0);
      hold = ($urandom_range(3) == 0);
      dir  = 1'($urandom);
      if ($urandom_range(63) == 0) src = ~src;
      if ($urandom_range(2) == 0) ext = ~ext;
      unused_in = 1'($urandom);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
